// File: rtl/wiener_stats_pkg.sv
// Shared types and sizing helpers for the Wiener block statistics engine.
package wiener_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACC_MEAN  = 3'd1,
    ST_MEAN_OUT  = 3'd2,
    ST_WAIT_VAR  = 3'd3,
    ST_ACC_VAR   = 3'd4,
    ST_VAR_FLUSH = 3'd5
  } stats_state_t;

  localparam int MEAN_READY_CYCLES = 2;

  // Squared-deviation accumulator: one 2*DW square per sample, TOTAL_SAMPLES of them.
  function automatic int acc_width(input int data_width, input int log2_samples);
    return 2 * data_width + log2_samples;
  endfunction

endpackage

// File: rtl/wiener_sq_diff.sv
// Registered squared deviation (x - mean)^2 with a one-cycle latency.
module wiener_sq_diff #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH-1:0]   mean,
  input  logic                    valid_in,
  output logic [2*DATA_WIDTH-1:0] sq,
  output logic                    valid_out
);

  logic signed [DATA_WIDTH:0] diff;
  logic        [DATA_WIDTH:0] mag;
  logic [2*DATA_WIDTH-1:0]    mag_ext;
  logic [2*DATA_WIDTH-1:0]    sq_d;
  logic [2*DATA_WIDTH-1:0]    sq_q;
  logic                       valid_q;

  assign diff = $signed({1'b0, data_in}) - $signed({1'b0, mean});
  // |diff| never exceeds 2^DATA_WIDTH-1, so the square fits in 2*DATA_WIDTH bits.
  assign mag     = diff[DATA_WIDTH] ? -diff : diff;
  assign mag_ext = {{(DATA_WIDTH-1){1'b0}}, mag};
  assign sq_d    = mag_ext * mag_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) sq_q <= sq_d;
    end
  end

  assign sq        = sq_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/wiener_block_stats_engine.sv
// Two-pass block mean / variance engine, responder side of the stats-FSM handshake.
//   state        | meaning
//   ST_IDLE      | waiting for start_of_data
//   ST_ACC_MEAN  | summing pass-1 samples
//   ST_MEAN_OUT  | mean_ready asserted for MEAN_READY_CYCLES
//   ST_WAIT_VAR  | waiting for variance_start_of_data (start_of_data aborts)
//   ST_ACC_VAR   | accumulating squared deviations of pass-2 samples
//   ST_VAR_FLUSH | last square lands, variance registered
module wiener_block_stats_engine
  import wiener_stats_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_of_data,
  input  logic                    variance_start_of_data,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   mean_out,
  output logic                    mean_ready,
  output logic [2*DATA_WIDTH-1:0] variance_out,
  output logic                    variance_ready,
  output logic                    busy,
  output logic                    block_abort
);

  localparam int LOG2_SAMPLES = $clog2(TOTAL_SAMPLES);
  localparam int SUM_W        = DATA_WIDTH + LOG2_SAMPLES;
  localparam int ACC_W        = acc_width(DATA_WIDTH, LOG2_SAMPLES);
  localparam int CNT_W        = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_MRDY  = CNT_W'(MEAN_READY_CYCLES - 1);

  stats_state_t            state_q, state_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [DATA_WIDTH-1:0]   mean_q, mean_d;
  logic [2*DATA_WIDTH-1:0] var_q, var_d;
  logic                    var_rdy_q, var_rdy_d;
  logic                    abort_q, abort_d;

  logic                    sod, vsod;
  logic                    sq_vin;
  logic [2*DATA_WIDTH-1:0] sq;
  logic                    sq_valid;

  assign sod     = start_of_data && data_valid;
  assign vsod    = variance_start_of_data && data_valid;
  assign cnt_inc = cnt_q + CNT_W'(1);

  wiener_sq_diff #(.DATA_WIDTH(DATA_WIDTH)) u_sq_diff (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .mean      (mean_q),
    .valid_in  (sq_vin),
    .sq        (sq),
    .valid_out (sq_valid)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mean_d    = mean_q;
    var_d     = var_q;
    var_rdy_d = 1'b0;
    abort_d   = 1'b0;
    sq_vin    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sod) begin
          sum_d   = SUM_W'(data_in);
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC_MEAN;
        end
      end

      ST_ACC_MEAN: begin
        if (sod) begin
          abort_d = 1'b1;
          sum_d   = SUM_W'(data_in);
          cnt_d   = CNT_W'(1);
        end else if (data_valid) begin
          sum_d = sum_q + SUM_W'(data_in);
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            mean_d  = sum_d[SUM_W-1:LOG2_SAMPLES];
            cnt_d   = '0;
            state_d = ST_MEAN_OUT;
          end
        end
      end

      ST_MEAN_OUT: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_MRDY) begin
          cnt_d   = '0;
          state_d = ST_WAIT_VAR;
        end
      end

      ST_WAIT_VAR: begin
        // variance_start_of_data takes priority when both pulses coincide.
        if (vsod) begin
          acc_d   = '0;
          cnt_d   = CNT_W'(1);
          sq_vin  = 1'b1;
          state_d = ST_ACC_VAR;
        end else if (sod) begin
          abort_d = 1'b1;
          sum_d   = SUM_W'(data_in);
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC_MEAN;
        end
      end

      ST_ACC_VAR: begin
        if (sq_valid) acc_d = acc_q + ACC_W'(sq);
        if (sod) begin
          abort_d = 1'b1;
          sum_d   = SUM_W'(data_in);
          cnt_d   = CNT_W'(1);
          state_d = ST_ACC_MEAN;
        end else if (data_valid) begin
          sq_vin = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_VAR_FLUSH;
          end
        end
      end

      ST_VAR_FLUSH: begin
        if (sq_valid) acc_d = acc_q + ACC_W'(sq);
        var_d     = acc_d[ACC_W-1:LOG2_SAMPLES];
        var_rdy_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mean_q    <= '0;
      var_q     <= '0;
      var_rdy_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mean_q    <= mean_d;
      var_q     <= var_d;
      var_rdy_q <= var_rdy_d;
      abort_q   <= abort_d;
    end
  end

  assign mean_out       = mean_q;
  assign mean_ready     = (state_q == ST_MEAN_OUT);
  assign variance_out   = var_q;
  assign variance_ready = var_rdy_q;
  assign busy           = (state_q != ST_IDLE);
  assign block_abort    = abort_q;

endmodule
